sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/sram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_sram_fifo_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: 4-word x 4-bit FIFO built on an external single-port SRAM
// plus a one-word registered output stage. Writes (push) and fetches
// (SRAM -> output register) share the SRAM port; a priority bit alternates
// the winner whenever both want the port in the same cycle.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         synchronous active-low reset
//   push_valid  upstream offers push_data
//   push_ready  push accepted this cycle (combinational write grant)
//   push_data   write payload
//   pop_valid   pop_data holds a valid word (registered)
//   pop_ready   downstream consumes pop_data this cycle
//   pop_data    registered read payload
//   count       words held: SRAM occupancy + output register (0..5)
//   empty       count == 0
//   sram_we     SRAM write enable
//   sram_addr   SRAM address
//   sram_wdata  SRAM write data
//   sram_rdata  SRAM read data, combinational on sram_addr
module sram_fifo_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic [3:0] push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output logic [3:0] pop_data,
  output logic [2:0] count,
  output logic       empty,
  output logic       sram_we,
  output logic [1:0] sram_addr,
  output logic [3:0] sram_wdata,
  input  logic [3:0] sram_rdata
);

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] DEPTH = CW'(4);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] mcount_q, mcount_d;
  logic          pri_q, pri_d;
  logic          pop_valid_q, pop_valid_d;
  logic [DW-1:0] pop_data_q, pop_data_d;

  logic wr_req, fe_req, wr_gnt, fe_gnt;

  // Request, arbitration, SRAM port drive and next-state
  always_comb begin
    wr_req      = push_valid && (mcount_q < DEPTH);
    fe_req      = (mcount_q != '0) && (!pop_valid_q || pop_ready);
    // Grants are suppressed during reset so nothing is accepted or fetched.
    wr_gnt      = rst && wr_req && (!fe_req || !pri_q);
    fe_gnt      = rst && fe_req && (!wr_req || pri_q);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mcount_d    = mcount_q;
    pri_d       = pri_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;

    // Only contested cycles flip priority, so an idle port keeps fairness state.
    if (wr_req && fe_req) begin
      pri_d = !pri_q;
    end

    if (wr_gnt) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      mcount_d = mcount_q + CW'(1);
    end

    if (fe_gnt) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      mcount_d    = mcount_q - CW'(1);
      pop_valid_d = 1'b1;
      pop_data_d  = sram_rdata;
    end else if (pop_valid_q && pop_ready) begin
      pop_valid_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mcount_q    <= '0;
      pri_q       <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mcount_q    <= mcount_d;
      pri_q       <= pri_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  // SRAM port: address follows the fetch pointer only on a fetch grant
  assign sram_we    = wr_gnt;
  assign sram_addr  = fe_gnt ? rd_ptr_q : wr_ptr_q;
  assign sram_wdata = push_data;

  assign push_ready = wr_gnt;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;
  assign count      = mcount_q + CW'(pop_valid_q);
  assign empty      = (count == '0);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: randomized and directed checks of sram_fifo_ctrl against a
// queue-based reference model, with a behavioural 4x4 SRAM attached.
`timescale 1ns/1ps
module tb_sram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [3:0] push_data = 4'h0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [3:0] pop_data;
  logic [2:0] count;
  logic       empty;
  logic       sram_we;
  logic [1:0] sram_addr;
  logic [3:0] sram_wdata;
  logic [3:0] sram_rdata;

  int unsigned checks = 0;
  int unsigned failures = 0;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .empty      (empty),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, combinational read, never cleared
  logic [3:0] mem [4];
  initial for (int i = 0; i < 4; i++) mem[i] = 4'h0;
  always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  // Reference model: SRAM contents as a queue, output register, write/fetch totals
  logic [3:0]  m_q[$];
  bit          m_ov  = 1'b0;
  logic [3:0]  m_od  = 4'h0;
  int unsigned m_wcnt = 0;
  int unsigned m_rcnt = 0;
  bit          m_pri = 1'b0;

  function automatic void arb(input bit pv, input bit pr, output bit wreq,
                              output bit freq, output bit wg, output bit fg);
    wreq = pv && (m_q.size() < 4);
    freq = (m_q.size() > 0) && (!m_ov || pr);
    wg   = wreq && (!freq || !m_pri);
    fg   = freq && (!wreq || m_pri);
  endfunction

  task automatic model_step();
    bit wreq, freq, wg, fg;
    if (!rst) begin
      m_q.delete(); m_ov = 1'b0; m_od = 4'h0; m_wcnt = 0; m_rcnt = 0; m_pri = 1'b0;
    end else begin
      arb(push_valid, pop_ready, wreq, freq, wg, fg);
      if (wreq && freq) m_pri = !m_pri;
      if (fg) begin
        m_od = m_q.pop_front(); m_ov = 1'b1; m_rcnt++;
      end else if (m_ov && pop_ready) begin
        m_ov = 1'b0;
      end
      if (wg) begin
        m_q.push_back(push_data); m_wcnt++;
      end
    end
  endtask

  // Per-cycle scoreboard of every output against the model
  task automatic scoreboard();
    bit wreq, freq, wg, fg;
    logic [1:0] eaddr;
    arb(push_valid, pop_ready, wreq, freq, wg, fg);
    if (!rst) begin wg = 1'b0; fg = 1'b0; end
    eaddr = fg ? 2'(m_rcnt) : 2'(m_wcnt);
    checks++;
    if (push_ready !== wg) begin failures++;
      $display("FAIL sb_push_ready t=%0t got=%b exp=%b", $time, push_ready, wg); end
    checks++;
    if (sram_we !== wg) begin failures++;
      $display("FAIL sb_sram_we t=%0t got=%b exp=%b", $time, sram_we, wg); end
    checks++;
    if (sram_addr !== eaddr) begin failures++;
      $display("FAIL sb_sram_addr t=%0t got=%0d exp=%0d", $time, sram_addr, eaddr); end
    if (!fg) begin
      checks++;
      if (sram_wdata !== push_data) begin failures++;
        $display("FAIL sb_sram_wdata t=%0t got=%h exp=%h", $time, sram_wdata, push_data); end
    end
    checks++;
    if (pop_valid !== m_ov) begin failures++;
      $display("FAIL sb_pop_valid t=%0t got=%b exp=%b", $time, pop_valid, m_ov); end
    if (m_ov) begin
      checks++;
      if (pop_data !== m_od) begin failures++;
        $display("FAIL sb_pop_data t=%0t got=%h exp=%h", $time, pop_data, m_od); end
    end
    checks++;
    if (count !== 3'(m_q.size() + int'(m_ov))) begin failures++;
      $display("FAIL sb_count t=%0t got=%0d exp=%0d", $time, count, m_q.size() + int'(m_ov)); end
    checks++;
    if (empty !== ((m_q.size() + int'(m_ov)) == 0)) begin failures++;
      $display("FAIL sb_empty t=%0t got=%b", $time, empty); end
  endtask

  task automatic drive(input bit r, input bit pv, input logic [3:0] pd, input bit pr);
    rst = r; push_valid = pv; push_data = pd; pop_ready = pr;
  endtask

  task automatic to_negedge();
    @(negedge clk);
    scoreboard();
  endtask

  task automatic to_posedge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 4'h0, 1'b0);
    to_negedge(); to_posedge();
    drive(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 4'h5, 1'b1);
    repeat (2) begin
      to_negedge();
      checks++;
      if (push_ready !== 1'b0) begin failures++;
        $display("FAIL reset_push_ready got=%b exp=0", push_ready); end
      to_posedge();
    end
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    to_negedge();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || pop_data !== 4'h0) begin
      failures++;
      $display("FAIL reset_state count=%0d empty=%b pop_valid=%b pop_data=%h exp 0/1/0/0",
               count, empty, pop_valid, pop_data);
    end
    to_posedge();
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 1'b1, 4'hA, 1'b0);
    to_negedge();
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== 2'd0 || push_ready !== 1'b1) begin failures++;
      $display("FAIL single_write we=%b addr=%0d ready=%b exp 1/0/1", sram_we, sram_addr, push_ready); end
    to_posedge();
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    to_negedge(); to_posedge();
    to_negedge();
    checks++;
    if (pop_valid !== 1'b1 || pop_data !== 4'hA || count !== 3'd1) begin failures++;
      $display("FAIL single_latency pop_valid=%b pop_data=%h count=%0d exp 1/a/1",
               pop_valid, pop_data, count); end
    to_posedge();
  endtask

  task automatic test_fill();
    int n = 1;
    int accepted = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, n <= 6, 4'(n), 1'b0);
      to_negedge();
      if (push_valid && push_ready) begin accepted++; n++; end
      to_posedge();
    end
    checks++;
    if (accepted != 5) begin failures++;
      $display("FAIL fill_accepted got=%0d exp=5", accepted); end
    drive(1'b1, 1'b1, 4'h6, 1'b0);
    to_negedge();
    checks++;
    if (push_ready !== 1'b0 || count !== 3'd5 || pop_valid !== 1'b1 || pop_data !== 4'h1) begin
      failures++;
      $display("FAIL fill_full ready=%b count=%0d pop_valid=%b pop_data=%h exp 0/5/1/1",
               push_ready, count, pop_valid, pop_data);
    end
    to_posedge();
  endtask

  task automatic test_back_to_back();
    int next_push = 6;
    int expect_out = 1;
    for (int c = 0; c < 24; c++) begin
      drive(1'b1, 1'b1, 4'(next_push), 1'b1);
      to_negedge();
      if (pop_valid && pop_ready) begin
        checks++;
        if (pop_data !== 4'(expect_out)) begin failures++;
          $display("FAIL b2b_order got=%h exp=%h", pop_data, 4'(expect_out)); end
        expect_out++;
      end
      if (push_ready) next_push++;
      to_posedge();
    end
    checks++;
    if (expect_out < 11) begin failures++;
      $display("FAIL b2b_throughput consumed=%0d exp>=10", expect_out - 1); end
  endtask

  task automatic test_random();
    logic [3:0] sent[$];
    int n_sent = 0;
    int n_got = 0;
    bit pv;
    do_reset();
    for (int c = 0; c < 400 && n_got < 12; c++) begin
      pv = (n_sent < 12) && ($urandom_range(0, 1) == 1);
      drive(1'b1, pv, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
      to_negedge();
      if (push_valid && push_ready) begin sent.push_back(push_data); n_sent++; end
      if (pop_valid && pop_ready) begin
        checks++;
        if (sent.size() == 0) begin failures++;
          $display("FAIL rand_extra got=%h exp=none", pop_data);
        end else begin
          if (pop_data !== sent[0]) begin failures++;
            $display("FAIL rand_order idx=%0d got=%h exp=%h", n_got, pop_data, sent[0]); end
          void'(sent.pop_front());
        end
        n_got++;
      end
      to_posedge();
    end
    checks++;
    if (n_got != 12) begin failures++;
      $display("FAIL rand_timeout got=%0d words exp=12", n_got); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    do_reset();
    for (int c = 0; c < 20 && count != 3'd3; c++) begin
      drive(1'b1, 1'b1, 4'(c + 1), 1'b0);
      to_negedge(); to_posedge();
    end
    checks++;
    if (count !== 3'd3) begin failures++;
      $display("FAIL midrst_fill count=%0d exp=3", count); end
    drive(1'b0, 1'b1, 4'h9, 1'b1);
    to_negedge(); to_posedge();
    drive(1'b1, 1'b0, 4'h0, 1'b0);
    to_negedge();
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0 || empty !== 1'b1) begin failures++;
      $display("FAIL midrst_clear count=%0d pop_valid=%b empty=%b exp 0/0/1", count, pop_valid, empty); end
    to_posedge();
    drive(1'b1, 1'b1, 4'h7, 1'b0);
    to_negedge();
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== 2'd0) begin failures++;
      $display("FAIL midrst_write we=%b addr=%0d exp 1/0", sram_we, sram_addr); end
    to_posedge();
    drive(1'b1, 1'b0, 4'h0, 1'b1);
    for (int c = 0; c < 10 && !seen; c++) begin
      to_negedge();
      if (pop_valid) begin
        seen = 1'b1;
        checks++;
        if (pop_data !== 4'h7) begin failures++;
          $display("FAIL midrst_pop got=%h exp=7", pop_data); end
      end
      to_posedge();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL midrst_timeout pop_valid never rose");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
